// File: rtl/fetch_unit_pkg.sv
// Shared NBBPU fetch definitions: widths, reset vector, state and PC-select encodings.
package fetch_unit_pkg;

  localparam int unsigned NBBPU_WIDTH = 16;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_TARGET   = 2'd2,
    PC_REDIRECT = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel plus fetch/decode instruction handoff.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 16
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_unit_pc_unit.sv
// Program counter and pending redirect address, updated on the falling edge.
module fetch_unit_pc_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH        = NBBPU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  pc_sel_t          sel,
  input  logic             redirect_load,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] pc_next;

  // Next-PC mux: hold, sequential (wraps at 2^WIDTH), branch target or saved redirect.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD:     pc_next = pc;
      PC_INC:      pc_next = WIDTH'(pc + WIDTH'(1));
      PC_TARGET:   pc_next = target;
      PC_REDIRECT: pc_next = redirect_pc;
      default:     pc_next = pc;
    endcase
  end

  // PC and redirect registers with synchronous reset.
  always_ff @(negedge clock) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      redirect_pc <= '0;
    end else begin
      pc <= pc_next;
      if (redirect_load) redirect_pc <= target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// NBBPU instruction fetch: owns the PC, requests imem, buffers one instruction for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH        = NBBPU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  output logic             halted,
  output logic [WIDTH-1:0] pc,
  fetch_unit_if.master     bus
);

  fetch_state_t     state;
  logic             halt_pend;
  logic             halt_now;
  pc_sel_t          pc_sel;
  logic             redirect_load;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;

  assign halt_now = halt | halt_pend;

  // Request is a pure decode of registered state and pc, so it stays stable until accepted.
  assign bus.imem_req    = (state == FETCH) || (state == FLUSH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;

  // PC update selection; halt suppresses every redirect and increment.
  always_comb begin
    pc_sel        = PC_HOLD;
    redirect_load = 1'b0;
    case (state)
      FETCH: begin
        if (!halt_now) begin
          if (bus.imem_ready) pc_sel = branch_taken ? PC_TARGET : PC_INC;
          else if (branch_taken) redirect_load = 1'b1;
        end
      end
      VALID: begin
        if (!halt_now && branch_taken) pc_sel = PC_TARGET;
      end
      FLUSH: begin
        if (!halt_now) begin
          if (bus.imem_ready) pc_sel = branch_taken ? PC_TARGET : PC_REDIRECT;
          else if (branch_taken) redirect_load = 1'b1;
        end
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  fetch_unit_pc_unit #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_unit (
    .clock         (clock),
    .reset         (reset),
    .sel           (pc_sel),
    .redirect_load (redirect_load),
    .target        (branch_target),
    .pc            (pc)
  );

  // Fetch FSM with registered instruction buffer, sticky halt and halted flag.
  always_ff @(negedge clock) begin
    if (reset) begin
      state       <= FETCH;
      halt_pend   <= 1'b0;
      halted      <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      halt_pend <= halt_pend | halt;
      case (state)
        FETCH: begin
          if (bus.imem_ready) begin
            if (halt_now) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (!branch_taken) begin
              instr       <= bus.imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end else if (!halt_now && branch_taken) begin
            state <= FLUSH;
          end
        end
        VALID: begin
          if (halt_now) begin
            instr_valid <= 1'b0;
            state       <= HALT;
            halted      <= 1'b1;
          end else if (branch_taken || bus.instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        FLUSH: begin
          if (bus.imem_ready) begin
            if (halt_now) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns A000+addr after a programmable wait count.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        halted;
  logic [15:0] pc;

  int          checks   = 0;
  int          failures = 0;
  int          mem_wait = 0;
  int          wait_cnt = 0;

  fetch_unit_if #(.WIDTH(16)) bus ();

  fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted),
    .pc            (pc),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  // Memory model: ready after mem_wait idle cycles of an asserted request.
  assign bus.imem_ready = bus.imem_req && (wait_cnt >= mem_wait);
  assign bus.imem_rdata = 16'(16'hA000 + bus.imem_addr);

  always @(negedge clock) begin
    if (reset || !bus.imem_req || bus.imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past one active (falling) edge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = 16'h0; halt = 1'b0;
    bus.instr_ready = 1'b1;
    mem_wait = 0;
    tick(); tick();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_instr", 32'(bus.instr), 32'h0000);
    check("rst_req", 32'(bus.imem_req), 32'd1);
    reset = 1'b0;

    // Zero-wait streaming: one instruction every two cycles.
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", 32'(bus.imem_addr), 32'(i));
      tick();
      check("seq_valid", 32'(bus.instr_valid), 32'd1);
      check("seq_instr", 32'(bus.instr), 32'(16'hA000 + 16'(i)));
      check("seq_pc", 32'(bus.instr_pc), 32'(i));
      check("seq_req_off", 32'(bus.imem_req), 32'd0);
      if (i < 2) begin
        tick();
        check("seq_gap", 32'(bus.instr_valid), 32'd0);
      end
    end

    // Backpressure: instruction held for 5 cycles, no requests.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_instr", 32'(bus.instr), 32'h0000A002);
      check("bp_pc", 32'(bus.instr_pc), 32'h0002);
      check("bp_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("bp_accept_req", 32'(bus.imem_req), 32'd1);
    check("bp_accept_addr", 32'(bus.imem_addr), 32'h0003);

    // Branch on first wait cycle of a 3-wait request: flush stale word.
    mem_wait = 3;
    branch_taken = 1'b1; branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fl_req", 32'(bus.imem_req), 32'd1);
      check("fl_addr_held", 32'(bus.imem_addr), 32'h0003);
      check("fl_no_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    check("fl_valid_after", 32'(bus.instr_valid), 32'd0);
    check("fl_new_addr", 32'(bus.imem_addr), 32'h0040);
    check("fl_new_req", 32'(bus.imem_req), 32'd1);
    mem_wait = 0;
    tick();
    check("fl_instr", 32'(bus.instr), 32'h0000A040);
    check("fl_instr_pc", 32'(bus.instr_pc), 32'h0040);

    // Branch in VALID with instr_ready: buffered instruction killed.
    branch_taken = 1'b1; branch_target = 16'h0100;
    tick();
    branch_taken = 1'b0;
    check("vb_valid", 32'(bus.instr_valid), 32'd0);
    check("vb_addr", 32'(bus.imem_addr), 32'h0100);
    tick();
    check("vb_instr", 32'(bus.instr), 32'h0000A100);
    check("vb_instr_pc", 32'(bus.instr_pc), 32'h0100);

    // PC wrap at FFFF.
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    branch_taken = 1'b0;
    check("wr_addr", 32'(bus.imem_addr), 32'hFFFF);
    tick();
    check("wr_instr_pc", 32'(bus.instr_pc), 32'hFFFF);
    check("wr_instr", 32'(bus.instr), 32'h00009FFF);
    tick();
    check("wr_next_addr", 32'(bus.imem_addr), 32'h0000);

    // Halt with branch during an outstanding 2-wait request.
    mem_wait = 2;
    halt = 1'b1; branch_taken = 1'b1; branch_target = 16'h0200;
    tick();
    halt = 1'b0; branch_taken = 1'b0;
    check("hl_req_pend", 32'(bus.imem_req), 32'd1);
    check("hl_not_yet", 32'(halted), 32'd0);
    check("hl_addr", 32'(bus.imem_addr), 32'h0000);
    tick(); tick();
    check("hl_halted", 32'(halted), 32'd1);
    check("hl_req_off", 32'(bus.imem_req), 32'd0);
    check("hl_valid", 32'(bus.instr_valid), 32'd0);
    check("hl_pc", 32'(pc), 32'h0000);
    tick(); tick();
    check("hl_sticky", 32'(halted), 32'd1);
    check("hl_sticky_req", 32'(bus.imem_req), 32'd0);

    // Synchronous reset restarts fetching from the reset vector.
    mem_wait = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_halted", 32'(halted), 32'd0);
    check("rr_pc", 32'(pc), 32'h0000);
    check("rr_req", 32'(bus.imem_req), 32'd1);
    tick();
    check("rr_valid", 32'(bus.instr_valid), 32'd1);
    check("rr_instr", 32'(bus.instr), 32'h0000A000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
